// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU select codes, NZVC flag bit positions and the
// state type of the sequential multiplier.
package cpu_pkg;

    // ALU operation select codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOT  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_SHR  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_ROR  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;
    localparam logic [3:0] ALU_INC  = 4'd11;
    localparam logic [3:0] ALU_DEC  = 4'd12;

    // Bit positions inside the ALU flag vector {N,Z,V,C}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    // Multiplier sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned 8x8 -> 16-bit shift-add multiplier that borrows the shared
// combinational ALU for its additions, one iteration per clock.
module alu_mul_seq
    import cpu_pkg::*;
#(
    parameter int ITER = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        zero,
    output logic        alu_own,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_sel,
    input  logic [7:0]  alu_result,
    input  logic [3:0]  alu_nzvc
);

    mul_state_t  state;
    logic [7:0]  m;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [2:0]  cnt;
    logic        zero_flag;
    logic [15:0] step_next;

    // Only the carry flag matters for an unsigned add; N, Z and V are dropped.
    logic unused_flags;
    assign unused_flags = ^alu_nzvc[FLAG_N:FLAG_V];

    // The ALU always sees the accumulator high byte plus the multiplicand.
    assign alu_a   = hi;
    assign alu_b   = m;
    assign alu_sel = ALU_ADD;

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign alu_own = (state == RUN);
    assign product = {hi, lo};
    assign zero    = zero_flag;

    // One shift-add step: add the multiplicand into hi when the current
    // multiplier bit is set, then shift {carry,hi,lo} right by one.
    always_comb begin
        step_next = {1'b0, hi, lo[7:1]};
        if (lo[0]) begin
            step_next = {alu_nzvc[FLAG_C], alu_result, lo[7:1]};
        end
    end

    // Sequencer state and datapath registers; reset aborts any operation.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            m         <= 8'd0;
            hi        <= 8'd0;
            lo        <= 8'd0;
            cnt       <= 3'd0;
            zero_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m         <= op_a;
                        hi        <= 8'd0;
                        lo        <= op_b;
                        cnt       <= 3'd0;
                        zero_flag <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    {hi, lo} <= step_next;
                    cnt      <= cnt + 3'd1;
                    if (cnt == 3'(ITER - 1)) begin
                        // Zero is judged on the final product as it enters DONE
                        zero_flag <= (step_next == 16'd0);
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural 8-bit ALU attached.
module tb_alu_mul_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        zero;
    logic        alu_own;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_result;
    logic [3:0]  alu_nzvc;

    int total = 0;
    int bad   = 0;
    int busy_cnt = 0;
    int own_cnt  = 0;
    int done_cnt = 0;
    bit carry_seen = 0;
    logic [15:0] last_prod = 16'd0;
    logic        last_zero = 1'b0;
    logic [16:0] sb [$];

    alu_mul_seq #(.ITER(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .zero       (zero),
        .alu_own    (alu_own),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_nzvc   (alu_nzvc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural ALU: only ADD is needed, flags {N,Z,V,C}
    always_comb begin
        logic [8:0] sum;
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[7:0];
        alu_nzvc   = {sum[7], (sum[7:0] == 8'd0),
                      (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]), sum[8]};
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops an expectation for every done pulse and tracks occupancy
    always @(negedge clock) begin
        logic [16:0] e;
        if (reset) begin
            if (busy) busy_cnt++;
            if (alu_own) begin
                own_cnt++;
                if (alu_nzvc[0]) carry_seen = 1'b1;
                check("alu_sel", 32'(alu_sel), 32'd0);
            end
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("product", 32'(product), 32'(e[16:1]));
                    check("zero", 32'(zero), 32'(e[0]));
                    $display("mul done: product=%04h zero=%0d expected=%04h/%0d",
                             product, zero, e[16:1], e[0]);
                end
            end
        end
    end

    // Issue one multiply and follow it to completion; optionally pulse start
    // again during cycles 3 and 9 of the operation with other operands.
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp_p, input bit inject);
        int n;
        int d0;
        @(negedge clock);
        check("held_product", 32'(product), 32'(last_prod));
        check("held_zero", 32'(zero), 32'(last_zero));
        op_a = a;
        op_b = b;
        start = 1'b1;
        busy_cnt = 0;
        own_cnt  = 0;
        d0 = done_cnt;
        sb.push_back({exp_p, (exp_p == 16'd0)});
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clock); #1;
            n++;
            if (inject && (n == 2 || n == 8)) begin
                start = 1'b1;
                op_a = 8'hFF;
                op_b = 8'hFF;
            end else begin
                start = 1'b0;
            end
        end
        if (n >= 20) check("done_timeout", 32'd1, 32'd0);
        check("latency", 32'(n), 32'd8);
        @(posedge clock); #1;
        start = 1'b0;
        check("busy_after", 32'(busy), 32'd0);
        check("busy_cycles", 32'(busy_cnt), 32'd9);
        check("own_cycles", 32'(own_cnt), 32'd8);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        last_prod = exp_p;
        last_zero = (exp_p == 16'd0);
    endtask

    initial begin
        int d0;
        reset = 1'b0;
        start = 1'b0;
        op_a  = 8'd0;
        op_b  = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_own", 32'(alu_own), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        reset = 1'b1;

        run_mul(8'h0D, 8'h0B, 16'h008F, 1'b0);
        carry_seen = 1'b0;
        run_mul(8'hFF, 8'hFF, 16'hFE01, 1'b0);
        check("carry_seen", 32'(carry_seen), 32'd1);
        run_mul(8'h00, 8'hAB, 16'h0000, 1'b0);
        run_mul(8'h80, 8'h02, 16'h0100, 1'b0);

        // Extra start pulses mid-operation must be ignored
        run_mul(8'h12, 8'h34, 16'h03A8, 1'b1);
        d0 = done_cnt;
        repeat (12) @(posedge clock);
        #1;
        check("no_queued_done", 32'(done_cnt - d0), 32'd0);
        check("ignored_product", 32'(product), 32'h03A8);

        // Reset during the 4th RUN cycle aborts the multiply
        @(negedge clock);
        op_a = 8'h55;
        op_b = 8'h33;
        start = 1'b1;
        d0 = done_cnt;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_own", 32'(alu_own), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        reset = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        last_prod = 16'd0;
        last_zero = 1'b0;
        run_mul(8'h10, 8'h10, 16'h0100, 1'b0);

        // Back-to-back: starts in the first idle cycle after done
        run_mul(8'h07, 8'h06, 16'h002A, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
